approx_adder_mae_monitor: RTL and testbench

//  Downstream error monitor for the approximate ripple-carry adders: accepts operand pairs plus the

---
 rtl/approx_mon_pkg.sv | 20 ++
 rtl/approx_adder_mae_monitor_if.sv | 26 ++
 rtl/approx_err_absdiff.sv | 15 +
 rtl/approx_adder_mae_monitor.sv | 191 +++++++++++++++++++
 tb/tb_approx_adder_mae_monitor.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mon_pkg.sv
// Shared types and width helpers for the approximate-adder MAE monitor.
package approx_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of sums and per-sample errors for a given operand width.
    function automatic int unsigned err_w(input int unsigned width);
        return width + 1;
    endfunction

    // Error accumulator width: a full window of worst-case errors cannot overflow.
    function automatic int unsigned acc_w(input int unsigned width, input int unsigned samples_log2);
        return width + 1 + samples_log2;
    endfunction

endpackage

// File: rtl/approx_adder_mae_monitor_if.sv
// Operand/sum stream into the MAE monitor (valid/ready handshake).
interface approx_adder_mae_monitor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH:0]   approx_sum;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output approx_sum,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  approx_sum,
        output in_ready
    );
endinterface

// File: rtl/approx_err_absdiff.sv
// Combinational absolute difference of two unsigned values.
module approx_err_absdiff #(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] abs_diff_c
);

    // Subtract the smaller from the larger so the result is never negative.
    always_comb begin
        abs_diff_c = (x >= y) ? (x - y) : (y - x);
    end

endmodule

// File: rtl/approx_adder_mae_monitor.sv
// Windowed mean-absolute-error monitor for an approximate adder under test.
// Optional worst-case sample tracking is enabled by defining WORST_CASE_TRACK_EN;
// without it max_err/max_a/max_b read 0 and no tracking registers exist.
module approx_adder_mae_monitor
    import approx_mon_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned SAMPLES_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    approx_adder_mae_monitor_if.slave bus,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH:0]            mae,
    output logic [SAMPLES_LOG2:0]     err_count,
    output logic [WIDTH:0]            max_err,
    output logic [WIDTH-1:0]          max_a,
    output logic [WIDTH-1:0]          max_b
);

    localparam int unsigned ERR_W = err_w(WIDTH);
    localparam int unsigned ACC_W = acc_w(WIDTH, SAMPLES_LOG2);
    localparam int unsigned CNT_W = SAMPLES_LOG2 + 1;
    localparam logic [CNT_W-1:0] WINDOW = {1'b1, {SAMPLES_LOG2{1'b0}}};

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   accepted_q;
    logic [CNT_W-1:0]   accepted_d;
    logic               in_ready_q;
    logic               ready_d;
    logic               start_fire;
    logic               in_fire;
    logic               finish_c;

    logic               s1_valid_q;
    logic [ERR_W-1:0]   s1_exact_q;
    logic [ERR_W-1:0]   s1_approx_q;
    logic [ERR_W-1:0]   err_c;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;

    assign start_fire  = start && (state_q != RUN);
    assign in_fire     = bus.in_valid && in_ready_q;
    assign bus.in_ready = in_ready_q;

    // Next state, accepted-sample count and the registered-ready value.
    always_comb begin
        state_d    = state_q;
        accepted_d = accepted_q;
        ready_d    = 1'b0;
        finish_c   = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if ((accepted_q == WINDOW) && !s1_valid_q) begin
                    state_d  = DONE;
                    finish_c = 1'b1;
                end
            end
            DONE: if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (start_fire) begin
            accepted_d = '0;
        end else if (in_fire) begin
            accepted_d = accepted_q + CNT_W'(1);
        end
        ready_d = (state_d == RUN) && (accepted_d < WINDOW);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Handshake: accepted count, registered ready and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted_q <= '0;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
        end else begin
            accepted_q <= accepted_d;
            in_ready_q <= ready_d;
            busy       <= (state_d == RUN);
        end
    end

    // Stage 1: register exact sum and the adder's approximate sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
        end else begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                s1_exact_q  <= ERR_W'(bus.in_a) + ERR_W'(bus.in_b);
                s1_approx_q <= bus.approx_sum;
            end
        end
    end

    approx_err_absdiff #(
        .W (ERR_W)
    ) u_absdiff (
        .x          (s1_exact_q),
        .y          (s1_approx_q),
        .abs_diff_c (err_c)
    );

    // Stage 2: accumulate error magnitude and count erroneous samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_fire) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (s1_valid_q) begin
            acc_q <= acc_q + ACC_W'(err_c);
            cnt_q <= cnt_q + CNT_W'(err_c != '0);
        end
    end

    // Window results: published together when the pipe drains, cleared by start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            mae       <= '0;
            err_count <= '0;
        end else if (start_fire) begin
            done      <= 1'b0;
            mae       <= '0;
            err_count <= '0;
        end else if (finish_c) begin
            done      <= 1'b1;
            mae       <= acc_q[ACC_W-1:SAMPLES_LOG2];
            err_count <= cnt_q;
        end
    end

`ifdef WORST_CASE_TRACK_EN
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [ERR_W-1:0] max_err_q;
    logic [WIDTH-1:0] max_a_q;
    logic [WIDTH-1:0] max_b_q;

    // Carry operands alongside stage 1 so the worst sample can be identified.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_q <= '0;
            s1_b_q <= '0;
        end else if (in_fire) begin
            s1_a_q <= bus.in_a;
            s1_b_q <= bus.in_b;
        end
    end

    // Strictly-greater capture keeps the first sample on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_err_q <= '0;
            max_a_q   <= '0;
            max_b_q   <= '0;
        end else if (start_fire) begin
            max_err_q <= '0;
            max_a_q   <= '0;
            max_b_q   <= '0;
        end else if (s1_valid_q && (err_c > max_err_q)) begin
            max_err_q <= err_c;
            max_a_q   <= s1_a_q;
            max_b_q   <= s1_b_q;
        end
    end

    assign max_err = max_err_q;
    assign max_a   = max_a_q;
    assign max_b   = max_b_q;
`else
    assign max_err = '0;
    assign max_a   = '0;
    assign max_b   = '0;
`endif

endmodule

// File: tb/tb_approx_adder_mae_monitor.sv
// Scoreboard bench for approx_adder_mae_monitor (WIDTH=16, SAMPLES_LOG2=8).
module tb_approx_adder_mae_monitor;

    localparam int N = 256;

    typedef struct {
        int mae;
        int cnt;
        int mx;
        int ma;
        int mb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [16:0] mae, max_err;
    logic [8:0]  err_count;
    logic [15:0] max_a, max_b;

    approx_adder_mae_monitor_if #(.WIDTH(16)) bus ();

    approx_adder_mae_monitor #(
        .WIDTH        (16),
        .SAMPLES_LOG2 (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .mae       (mae),
        .err_count (err_count),
        .max_err   (max_err),
        .max_a     (max_a),
        .max_b     (max_b)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    logic [15:0] wa [N];
    logic [15:0] wb [N];
    logic [16:0] ws [N];

    int edge_cnt = 0;
    int last_xfer_edge = 0;
    int xfers = 0;
    int win_id = 0;
    int chk_win = -1;
    bit prev_done = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Fill the window arrays with one of the stimulus patterns.
    task automatic gen(input int kind);
        for (int i = 0; i < N; i++) begin
            int a, b, d;
            d = 0;
            case (kind)
                0: begin a = int'($urandom_range(0, 65535)); b = int'($urandom_range(0, 65535)); end
                1: begin a = int'($urandom_range(0, 32767)); b = int'($urandom_range(0, 32767)); d = 3; end
                2: begin
                    a = int'($urandom_range(5, 65535)); b = int'($urandom_range(0, 65535));
                    d = (i % 2 == 1) ? -5 : 0;
                end
                default: begin
                    a = int'($urandom_range(16, 65520)); b = int'($urandom_range(0, 65520));
                    d = int'($urandom_range(0, 20)) - 10;
                    if (kind == 4 && i == 37) begin a = 32'h1234; b = 32'h0F0F; d = 1000; end
                end
            endcase
            wa[i] = 16'(a);
            wb[i] = 16'(b);
            ws[i] = 17'(a + b + d);
        end
    endtask

    // Reference: plain-arithmetic statistics over the stored window.
    task automatic push_expected();
        exp_t   e;
        longint sum;
        sum = 0;
        e.cnt = 0; e.mx = 0; e.ma = 0; e.mb = 0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = (int'(wa[i]) + int'(wb[i])) - int'(ws[i]);
            if (d < 0) d = -d;
            sum += d;
            if (d != 0) e.cnt++;
            if (d > e.mx) begin e.mx = d; e.ma = int'(wa[i]); e.mb = int'(wb[i]); end
        end
        e.mae = int'(sum / N);
`ifndef WORST_CASE_TRACK_EN
        e.mx = 0; e.ma = 0; e.mb = 0;
`endif
        sb.push_back(e);
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Pulse start, then offer n samples with optional random gaps.
    task automatic drive(input int n, input bit gaps, input bit start_mid);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            int k;
            if (gaps) begin
                k = 0;
                while ($urandom_range(0, 1) == 1 && k < 8) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                    k++;
                end
            end
            bus.in_valid   = 1'b1;
            bus.in_a       = wa[i];
            bus.in_b       = wb[i];
            bus.approx_sum = ws[i];
            start          = start_mid && (i == 100);
            k = 0;
            while (!bus.in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (k >= 20) begin
                tests++; fails++;
                $display("FAIL in_ready_timeout: got 0 expected 1 at sample %0d", i);
                finish_run();
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", done, 1);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  bus.in_ready, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_mae"},       mae, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_max_err"},   max_err, 0);
        check({tag, "_max_a"},     max_a, 0);
        check({tag, "_max_b"},     max_b, 0);
    endtask

    // Transfer bookkeeping seen at the active edge.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            xfers = 0;
        end else begin
            if (start && !busy) begin
                xfers = 0;
                win_id++;
            end
            if (bus.in_valid && bus.in_ready) begin
                xfers++;
                last_xfer_edge = edge_cnt;
            end
        end
    end

    // Monitor: compare published window results against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (xfers == N && chk_win != win_id) begin
                check("in_ready_after_last", bus.in_ready, 0);
                chk_win = win_id;
            end
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mae",           mae, e.mae);
                    check("err_count",     err_count, e.cnt);
                    check("max_err",       max_err, e.mx);
                    check("max_a",         max_a, e.ma);
                    check("max_b",         max_b, e.mb);
                    check("done_latency",  edge_cnt - last_xfer_edge, 2);
                    check("window_xfers",  xfers, N);
                    check("busy_at_done",  busy, 0);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.approx_sum = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // in_valid in IDLE must not be taken.
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_ignores_valid", xfers, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        gen(0); push_expected(); drive(N, 1'b0, 1'b0); wait_done();
        gen(1); push_expected(); drive(N, 1'b0, 1'b1); wait_done();
        check("busy_in_done", busy, 0);
        gen(2); push_expected(); drive(N, 1'b0, 1'b0); wait_done();
        gen(3); push_expected(); drive(N, 1'b1, 1'b0); wait_done();
        push_expected(); drive(N, 1'b0, 1'b0); wait_done();

        // Abort a window with reset after 100 samples.
        gen(1); drive(100, 1'b0, 1'b0);
        check("busy_mid_run", busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        gen(0); push_expected(); drive(N, 1'b0, 1'b0); wait_done();

        gen(4); push_expected(); drive(N, 1'b1, 1'b0); wait_done();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        finish_run();
    end

endmodule
